axi4_sram_target: RTL and testbench

AXI4 burst-capable target (responder) backed by a synchronous single-port word RAM, with byte-lane write strobes. It is the far end of the debug bridge's AXI4 memory port and of any other AXI4 initiator in the SoC. It accepts one transaction at a time and supports FIXED, INCR and WRAP bursts of up to 256 beats. Every response is OKAY.

---
 rtl/axi4_sram_target.sv | 192 +++++++++++++++++++
 tb/tb_axi4_sram_target.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_target.sv
// AXI4 burst target (FIXED/INCR/WRAP, up to 256 beats) in front of a single-port
// word RAM with byte-lane strobes. One transaction in flight; every response is OKAY.
module axi4_sram_target #(
   parameter int MEM_ADDR_W = 12
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        awvalid_i,
   input  logic [31:0] awaddr_i,
   input  logic [3:0]  awid_i,
   input  logic [7:0]  awlen_i,
   input  logic [1:0]  awburst_i,
   output logic        awready_o,
   input  logic        wvalid_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        wlast_i,
   output logic        wready_o,
   output logic        bvalid_o,
   output logic [1:0]  bresp_o,
   output logic [3:0]  bid_o,
   input  logic        bready_i,
   input  logic        arvalid_i,
   input  logic [31:0] araddr_i,
   input  logic [3:0]  arid_i,
   input  logic [7:0]  arlen_i,
   input  logic [1:0]  arburst_i,
   output logic        arready_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic [3:0]  rid_o,
   output logic        rlast_o,
   input  logic        rready_i
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [1:0]  burst_q, burst_d;
   logic [3:0]  id_q, id_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [8:0]  remain_q, remain_d;
   logic        last_grant_w_q, last_grant_w_d;
   logic        rvalid_q, rvalid_d;
   logic        rlast_q, rlast_d;
   logic [31:0] rdata_q;

   logic        idle, grant_w, grant_r, w_hs, rd_en;
   logic [31:0] addr_nxt;
   logic [MEM_ADDR_W-1:0] word_idx;
   logic [31:0] mem [2**MEM_ADDR_W];
   logic        unused_wlast;

   // WRAP window is (len+1)*4 bytes, so its offset mask is simply {len, 2'b11}.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [1:0] burst);
      logic [31:0] inc;
      logic [31:0] mask;
      inc  = a + 32'd4;
      mask = {22'd0, len, 2'b11};
      next_addr = inc;
      if (burst == 2'd0)
         next_addr = a;
      else if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         next_addr = (a & ~mask) | (inc & mask);
   endfunction

   assign unused_wlast = wlast_i;
   assign word_idx     = addr_q[MEM_ADDR_W+1:2];
   assign addr_nxt     = next_addr(addr_q, len_q, burst_q);

   assign idle      = (state_q == S_IDLE);
   assign grant_r   = arvalid_i & (~awvalid_i | last_grant_w_q);
   assign grant_w   = awvalid_i & ~grant_r;
   assign awready_o = ~rst_i & idle & grant_w;
   assign arready_o = ~rst_i & idle & grant_r;

   assign wready_o = (state_q == S_WRITE);
   assign w_hs     = wready_o & wvalid_i;
   assign rd_en    = (state_q == S_READ) && (remain_q != 9'd0) && (!rvalid_q || rready_i);

   assign bvalid_o = (state_q == S_WRESP);
   assign bresp_o  = 2'b00;
   assign bid_o    = id_q;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign rresp_o  = 2'b00;
   assign rid_o    = id_q;
   assign rlast_o  = rlast_q;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      len_d          = len_q;
      burst_d        = burst_q;
      id_d           = id_q;
      cnt_d          = cnt_q;
      remain_d       = remain_q;
      last_grant_w_d = last_grant_w_q;
      rvalid_d       = rvalid_q;
      rlast_d        = rlast_q;
      case (state_q)
         S_IDLE: begin
            if (awready_o) begin
               addr_d         = awaddr_i;
               len_d          = awlen_i;
               burst_d        = awburst_i;
               id_d           = awid_i;
               cnt_d          = 8'd0;
               last_grant_w_d = 1'b1;
               state_d        = S_WRITE;
            end else if (arready_o) begin
               addr_d         = araddr_i;
               len_d          = arlen_i;
               burst_d        = arburst_i;
               id_d           = arid_i;
               cnt_d          = 8'd0;
               remain_d       = {1'b0, arlen_i} + 9'd1;
               last_grant_w_d = 1'b0;
               state_d        = S_READ;
            end
         end
         S_WRITE: begin
            if (w_hs) begin
               addr_d = addr_nxt;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == len_q) state_d = S_WRESP;
            end
         end
         S_WRESP: begin
            if (bready_i) state_d = S_IDLE;
         end
         S_READ: begin
            if (rd_en) begin
               addr_d   = addr_nxt;
               cnt_d    = cnt_q + 8'd1;
               remain_d = remain_q - 9'd1;
               rvalid_d = 1'b1;
               rlast_d  = (cnt_q == len_q);
            end else if (rvalid_q && rready_i) begin
               rvalid_d = 1'b0;
               if (rlast_q) begin
                  rlast_d = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         addr_q         <= 32'd0;
         len_q          <= 8'd0;
         burst_q        <= 2'd0;
         id_q           <= 4'd0;
         cnt_q          <= 8'd0;
         remain_q       <= 9'd0;
         last_grant_w_q <= 1'b1;
         rvalid_q       <= 1'b0;
         rlast_q        <= 1'b0;
         rdata_q        <= 32'd0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         len_q          <= len_d;
         burst_q        <= burst_d;
         id_q           <= id_d;
         cnt_q          <= cnt_d;
         remain_q       <= remain_d;
         last_grant_w_q <= last_grant_w_d;
         rvalid_q       <= rvalid_d;
         rlast_q        <= rlast_d;
         if (rd_en) rdata_q <= mem[word_idx];
      end
   end

   // RAM array itself is never reset; only its output register is.
   always_ff @(posedge clk_i) begin
      if (w_hs) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi4_sram_target.sv
// Scoreboard bench for axi4_sram_target: expected read data is queued when a
// read is issued and popped as R beats are accepted.
module tb_axi4_sram_target;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        awvalid_i = 1'b0;
   logic [31:0] awaddr_i = '0;
   logic [3:0]  awid_i = '0;
   logic [7:0]  awlen_i = '0;
   logic [1:0]  awburst_i = '0;
   logic        awready_o;
   logic        wvalid_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  wstrb_i = '0;
   logic        wlast_i = 1'b0;
   logic        wready_o;
   logic        bvalid_o;
   logic [1:0]  bresp_o;
   logic [3:0]  bid_o;
   logic        bready_i = 1'b0;
   logic        arvalid_i = 1'b0;
   logic [31:0] araddr_i = '0;
   logic [3:0]  arid_i = '0;
   logic [7:0]  arlen_i = '0;
   logic [1:0]  arburst_i = '0;
   logic        arready_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic [1:0]  rresp_o;
   logic [3:0]  rid_o;
   logic        rlast_o;
   logic        rready_i = 1'b0;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] wbuf[256];

   axi4_sram_target #(.MEM_ADDR_W(12)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .awvalid_i(awvalid_i), .awaddr_i(awaddr_i), .awid_i(awid_i), .awlen_i(awlen_i),
      .awburst_i(awburst_i), .awready_o(awready_o),
      .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
      .wready_o(wready_o),
      .bvalid_o(bvalid_o), .bresp_o(bresp_o), .bid_o(bid_o), .bready_i(bready_i),
      .arvalid_i(arvalid_i), .araddr_i(araddr_i), .arid_i(arid_i), .arlen_i(arlen_i),
      .arburst_i(arburst_i), .arready_o(arready_o),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rid_o(rid_o),
      .rlast_o(rlast_o), .rready_i(rready_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, output int n);
      @(posedge clk_i); #1;
      awvalid_i = 1'b1; awaddr_i = a; awlen_i = len; awburst_i = burst; awid_i = id;
      n = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         if (awready_o) begin n = cyc; break; end
      end
      n_cmp++;
      if (n < 0) begin n_err++; $display("FAIL aw_accept: awready stayed 0, required 1"); end
      @(posedge clk_i); #1;
      awvalid_i = 1'b0;
   endtask

   task automatic w_phase(input int n, input logic [7:0] len, input logic [3:0] strb,
                          input logic [3:0] id);
      int found;
      wvalid_i = 1'b1; wstrb_i = strb;
      for (int i = 0; i <= int'(len); i++) begin
         wdata_i = wbuf[i]; wlast_i = (i == int'(len));
         @(negedge clk_i);
         n_cmp++;
         if (wready_o !== 1'b1 || cyc != n + 1 + i) begin
            n_err++;
            $display("FAIL w_beat%0d: wready=%b cycle=%0d, required 1 at %0d", i, wready_o, cyc, n + 1 + i);
         end
         @(posedge clk_i); #1;
      end
      wvalid_i = 1'b0; wlast_i = 1'b0; bready_i = 1'b1;
      found = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         if (bvalid_o) begin found = 1; break; end
      end
      n_cmp++;
      if (found == 0 || cyc != n + 2 + int'(len)) begin
         n_err++;
         $display("FAIL b_timing: found=%0d cycle=%0d, required cycle %0d", found, cyc, n + 2 + int'(len));
      end
      n_cmp++;
      if (bid_o !== id || bresp_o !== 2'b00) begin
         n_err++;
         $display("FAIL b_resp: bid=%h bresp=%h, required bid=%h bresp=0", bid_o, bresp_o, id);
      end
      @(posedge clk_i); #1;
      bready_i = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input logic [3:0] strb);
      int n;
      aw_phase(a, len, burst, id, n);
      w_phase(n, len, strb, id);
   endtask

   task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, output int n);
      @(posedge clk_i); #1;
      arvalid_i = 1'b1; araddr_i = a; arlen_i = len; arburst_i = burst; arid_i = id;
      n = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         if (arready_o) begin n = cyc; break; end
      end
      n_cmp++;
      if (n < 0) begin n_err++; $display("FAIL ar_accept: arready stayed 0, required 1"); end
      @(posedge clk_i); #1;
      arvalid_i = 1'b0;
   endtask

   task automatic r_phase(input int n, input logic [7:0] len, input logic [3:0] id, input bit toggle);
      int beat, done, seen, stalled;
      logic [31:0] sdata, expd;
      logic slast;
      beat = 0; done = 0; seen = 0; stalled = 0; sdata = '0; slast = 1'b0;
      rready_i = 1'b1;
      for (int k = 0; k < 1000 && done == 0; k++) begin
         @(negedge clk_i);
         if (rvalid_o) begin
            if (seen == 0) begin
               seen = 1;
               n_cmp++;
               if (cyc != n + 2) begin
                  n_err++;
                  $display("FAIL r_first: first rvalid at cycle %0d, required %0d", cyc, n + 2);
               end
            end
            if (stalled != 0) begin
               n_cmp++;
               if (rdata_o !== sdata || rlast_o !== slast) begin
                  n_err++;
                  $display("FAIL r_stall: data=%h last=%b, required data=%h last=%b", rdata_o, rlast_o, sdata, slast);
               end
            end
            if (rready_i) begin
               expd = 32'hx;
               if (exp_q.size() > 0) expd = exp_q.pop_front();
               n_cmp++;
               if (rdata_o !== expd) begin
                  n_err++;
                  $display("FAIL r_data%0d: got %h, required %h", beat, rdata_o, expd);
               end
               n_cmp++;
               if (rlast_o !== (beat == int'(len)) || rid_o !== id || rresp_o !== 2'b00) begin
                  n_err++;
                  $display("FAIL r_ctl%0d: rlast=%b rid=%h rresp=%h, required rlast=%b rid=%h rresp=0",
                           beat, rlast_o, rid_o, rresp_o, beat == int'(len), id);
               end
               beat++;
               stalled = 0;
               if (beat > int'(len)) done = 1;
            end else begin
               stalled = 1; sdata = rdata_o; slast = rlast_o;
            end
         end
         @(posedge clk_i); #1;
         if (toggle) rready_i = ~rready_i;
      end
      if (done == 0) begin
         n_cmp++; n_err++;
         $display("FAIL r_timeout: %0d beats seen, required %0d", beat, int'(len) + 1);
      end
      rready_i = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input bit toggle);
      int n;
      ar_phase(a, len, burst, id, n);
      r_phase(n, len, id, toggle);
   endtask

   task automatic test_reset();
      awvalid_i = 1'b1; arvalid_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      n_cmp++;
      if (awready_o !== 1'b0 || arready_o !== 1'b0 || wready_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready: aw=%b ar=%b w=%b, required 0 0 0", awready_o, arready_o, wready_o);
      end
      n_cmp++;
      if (rvalid_o !== 1'b0 || bvalid_o !== 1'b0 || rlast_o !== 1'b0 || rdata_o !== 32'd0 ||
          rid_o !== 4'd0 || bid_o !== 4'd0 || bresp_o !== 2'd0 || rresp_o !== 2'd0) begin
         n_err++;
         $display("FAIL reset_out: rv=%b bv=%b rl=%b rd=%h rid=%h bid=%h, required all 0",
                  rvalid_o, bvalid_o, rlast_o, rdata_o, rid_o, bid_o);
      end
      awvalid_i = 1'b0; arvalid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
   endtask

   task automatic test_single();
      wbuf[0] = 32'hDEADBEEF;
      do_write(32'h10, 8'd0, 2'd1, 4'h7, 4'hF);
      exp_q.push_back(32'hDEADBEEF);
      do_read(32'h10, 8'd0, 2'd1, 4'h2, 1'b0);
      exp_q.push_back(32'hDEADBEEF);
      do_read(32'h10 + 32'h4000 + 32'h3, 8'd0, 2'd1, 4'h4, 1'b0);
   endtask

   task automatic test_strobes();
      wbuf[0] = 32'h11223344;
      do_write(32'h20, 8'd0, 2'd1, 4'h1, 4'hF);
      wbuf[0] = 32'hAABBCCDD;
      do_write(32'h20, 8'd0, 2'd1, 4'h1, 4'h5);
      exp_q.push_back(32'h11BB33DD);
      do_read(32'h20, 8'd0, 2'd1, 4'h1, 1'b0);
   endtask

   task automatic test_incr16();
      for (int i = 0; i < 16; i++) wbuf[i] = i * 32'h01010101;
      do_write(32'h100, 8'd15, 2'd1, 4'hA, 4'hF);
      for (int i = 0; i < 16; i++) exp_q.push_back(i * 32'h01010101);
      do_read(32'h100, 8'd15, 2'd1, 4'hB, 1'b1);
   endtask

   task automatic test_wrap_fixed();
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0000000 + i;
      do_write(32'h108, 8'd3, 2'd2, 4'h3, 4'hF);
      exp_q.push_back(32'hA0000002); exp_q.push_back(32'hA0000003);
      exp_q.push_back(32'hA0000000); exp_q.push_back(32'hA0000001);
      do_read(32'h100, 8'd3, 2'd1, 4'h3, 1'b0);
      exp_q.push_back(32'hA0000001); exp_q.push_back(32'hA0000002);
      exp_q.push_back(32'hA0000003); exp_q.push_back(32'hA0000000);
      do_read(32'h10C, 8'd3, 2'd2, 4'h6, 1'b0);
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hF0F00000 + i;
      do_write(32'h200, 8'd3, 2'd0, 4'h8, 4'hF);
      exp_q.push_back(32'hF0F00003);
      exp_q.push_back(32'hF0F00003);
      do_read(32'h200, 8'd1, 2'd0, 4'h8, 1'b0);
   endtask

   task automatic test_arb();
      int n;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      awvalid_i = 1'b1; awaddr_i = 32'h300; awlen_i = 8'd0; awburst_i = 2'd1; awid_i = 4'h3;
      arvalid_i = 1'b1; araddr_i = 32'h10; arlen_i = 8'd0; arburst_i = 2'd1; arid_i = 4'h9;
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk_i);
      n = cyc;
      n_cmp++;
      if (arready_o !== 1'b1 || awready_o !== 1'b0) begin
         n_err++;
         $display("FAIL arb_first: arready=%b awready=%b, required 1 0", arready_o, awready_o);
      end
      @(posedge clk_i); #1;
      arvalid_i = 1'b0;
      r_phase(n, 8'd0, 4'h9, 1'b0);
      arvalid_i = 1'b1;
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk_i);
      n = cyc;
      n_cmp++;
      if (awready_o !== 1'b1 || arready_o !== 1'b0) begin
         n_err++;
         $display("FAIL arb_second: awready=%b arready=%b, required 1 0", awready_o, arready_o);
      end
      @(posedge clk_i); #1;
      awvalid_i = 1'b0;
      wbuf[0] = 32'h0BADF00D;
      w_phase(n, 8'd0, 4'hF, 4'h3);
      n = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         if (arready_o) begin n = cyc; break; end
      end
      n_cmp++;
      if (n < 0) begin n_err++; $display("FAIL arb_pending: arready stayed 0, required 1"); end
      @(posedge clk_i); #1;
      arvalid_i = 1'b0;
      r_phase(n, 8'd0, 4'h9, 1'b0);
      exp_q.push_back(32'h0BADF00D);
      do_read(32'h300, 8'd0, 2'd1, 4'h5, 1'b0);
   endtask

   task automatic test_reset_mid();
      int n, beat;
      logic [31:0] expd;
      exp_q.push_back(32'hA0000002); exp_q.push_back(32'hA0000003);
      exp_q.push_back(32'hA0000000); exp_q.push_back(32'hA0000001);
      for (int i = 4; i < 8; i++) exp_q.push_back(i * 32'h01010101);
      ar_phase(32'h100, 8'd7, 2'd1, 4'hC, n);
      rready_i = 1'b1;
      beat = 0;
      for (int k = 0; k < 20 && beat < 3; k++) begin
         @(negedge clk_i);
         if (rvalid_o) begin
            expd = exp_q.pop_front();
            n_cmp++;
            if (rdata_o !== expd) begin
               n_err++;
               $display("FAIL rm_data%0d: got %h, required %h", beat, rdata_o, expd);
            end
            beat++;
            if (beat == 3) begin
               rst_i = 1'b1;
               #1;
               n_cmp++;
               if (rvalid_o !== 1'b0 || rlast_o !== 1'b0) begin
                  n_err++;
                  $display("FAIL rm_drop: rvalid=%b rlast=%b, required 0 0", rvalid_o, rlast_o);
               end
            end
         end
         if (beat < 3) begin @(posedge clk_i); #1; end
      end
      if (beat < 3) begin
         n_cmp++; n_err++;
         $display("FAIL rm_timeout: %0d beats seen, required 3", beat);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0; rready_i = 1'b0;
      exp_q.delete();
      @(negedge clk_i);
      n_cmp++;
      if (rvalid_o !== 1'b0 || bvalid_o !== 1'b0 || wready_o !== 1'b0) begin
         n_err++;
         $display("FAIL rm_idle: rvalid=%b bvalid=%b wready=%b, required 0 0 0", rvalid_o, bvalid_o, wready_o);
      end
      exp_q.push_back(32'hA0000000);
      do_read(32'h108, 8'd0, 2'd1, 4'hD, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_strobes();
      test_incr16();
      test_wrap_fixed();
      test_arb();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_empty: %0d entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
